counter_10: RTL and testbench



---
 rtl/counter_10_pkg.sv | 20 ++
 rtl/counter_10_dec.sv | 19 +
 rtl/counter_10.sv | 68 ++++++
 tb/tb_counter_10.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/counter_10_pkg.sv
// counter_10_pkg: shared constants and types for the single-digit BCD down-counter.
//   CNT_W       : digit width in bits
//   CNT_MAX     : largest legal BCD digit (wrap target)
//   CNT_MIN     : smallest legal BCD digit (terminal value)
//   bcd_digit_t : one BCD digit
//   is_bcd()    : true when a 4-bit value is a legal digit 0-9
package counter_10_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t CNT_MAX = 4'd9;
  localparam bcd_digit_t CNT_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t value);
    return (value <= CNT_MAX);
  endfunction

endpackage

// File: rtl/counter_10_dec.sv
// counter_10_dec: combinational BCD decrement with 0->9 wrap.
// Ports:
//   value      : current digit
//   next_value : value-1, or CNT_MAX when value is CNT_MIN
//   borrow     : high when value is CNT_MIN (decrement would wrap)
module counter_10_dec
  import counter_10_pkg::*;
(
  input  bcd_digit_t value,
  output bcd_digit_t next_value,
  output logic       borrow
);

  always_comb begin
    borrow     = (value == CNT_MIN);
    next_value = borrow ? CNT_MAX : bcd_digit_t'(value - 4'd1);
  end

endmodule

// File: rtl/counter_10.sv
// counter_10: single BCD digit down-counter for the timer chain.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, clears count
//   enable : decrement on the next rising edge
//   data   : digit to load
//   loadn  : synchronous active-low load, overrides enable
//   count  : current digit (registered)
//   tc     : borrow out to the next digit's enable (combinational)
//   zero   : count == 0 (combinational)
// Build option COUNTER_10_LOAD_CLAMP_EN: loads of 10-15 store 9; when
// undefined such loads are ignored and the count holds.
module counter_10
  import counter_10_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] data,
  input  logic             loadn,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output logic             zero
);

  bcd_digit_t count_d;
  bcd_digit_t dec_value;
  logic       dec_borrow;

  counter_10_dec u_dec (
    .value      (count),
    .next_value (dec_value),
    .borrow     (dec_borrow)
  );

  // Next-count mux: load (with out-of-range handling) > decrement > hold.
  always_comb begin
    count_d = count;
    if (!loadn) begin
      if (is_bcd(data)) begin
        count_d = data;
      end else begin
`ifdef COUNTER_10_LOAD_CLAMP_EN
        count_d = CNT_MAX;
`else
        count_d = count;
`endif
      end
    end else if (enable) begin
      count_d = dec_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CNT_MIN;
    end else begin
      count <= count_d;
    end
  end

  // Borrow is only real when a decrement will actually happen this edge.
  always_comb begin
    zero = (count == CNT_MIN);
    tc   = enable & dec_borrow & loadn & ~rst;
  end

endmodule

// File: tb/tb_counter_10.sv
module tb_counter_10;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] data;
  logic       loadn;
  logic [3:0] count;
  logic       tc;
  logic       zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       loadn;
    logic       enable;
    logic [3:0] data;
    logic       exp_tc;     // expected before the edge
    logic [3:0] exp_count;  // expected after the edge
    int         reps;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb_q[$];
  logic [3:0] model_cnt;

`ifdef COUNTER_10_LOAD_CLAMP_EN
  localparam logic [3:0] OOR_FROM3 = 4'd9;
`else
  localparam logic [3:0] OOR_FROM3 = 4'd3;
`endif

  counter_10 dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .data   (data),
    .loadn  (loadn),
    .count  (count),
    .tc     (tc),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ln, input logic en, input logic [3:0] d,
                     input logic etc, input logic [3:0] ec, input int reps = 1);
    vecs.push_back('{ln, en, d, etc, ec, reps});
  endtask

  // Drive one vector at the falling edge, check comb outputs, then check count after the edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    loadn  = v.loadn;
    enable = v.enable;
    data   = v.data;
    #1;
    check($sformatf("v%0d_tc", idx), int'(tc), int'(v.exp_tc));
    check($sformatf("v%0d_zero", idx), int'(zero), int'(model_cnt == 4'd0));
    sb_q.push_back(v.exp_count);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check($sformatf("v%0d_sb_empty", idx), 0, 1);
    end else begin
      model_cnt = sb_q.pop_front();
      check($sformatf("v%0d_count", idx), int'(count), int'(model_cnt));
    end
  endtask

  initial begin
    // Reset asserted with enable high: tc must stay masked.
    rst = 1'b1; enable = 1'b1; loadn = 1'b1; data = 4'd0;
    model_cnt = 4'd0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_zero", int'(zero), 1);
    check("rst_tc", int'(tc), 0);
    @(posedge clk); #1;
    check("rst_hold_count", int'(count), 0);
    check("rst_hold_tc", int'(tc), 0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;
    #1;
    check("release_count", int'(count), 0);

    add(1, 0, 0, 0, 0, 5);                 // idle after reset
    add(0, 0, 4, 0, 4);                    // load 4
    add(1, 0, 0, 0, 4, 10);                // hold 10 cycles
    add(0, 0, 8, 0, 8);                    // load 8
    add(1, 1, 0, 0, 7); add(1, 1, 0, 0, 6); add(1, 1, 0, 0, 5);
    add(1, 1, 0, 0, 4); add(1, 1, 0, 0, 3); add(1, 1, 0, 0, 2);
    add(1, 1, 0, 0, 1); add(1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 9);                    // wrap with tc
    add(1, 1, 0, 0, 8);
    add(1, 1, 0, 0, 7);
    add(0, 1, 5, 0, 5);                    // load wins over enable
    add(1, 1, 0, 0, 4); add(1, 1, 0, 0, 3); add(1, 1, 0, 0, 2);
    add(1, 1, 0, 0, 1); add(1, 1, 0, 0, 0);
    add(0, 1, 3, 0, 3);                    // at zero: loadn masks tc
    add(1, 0, 0, 0, 3);
    add(0, 0, 12, 0, OOR_FROM3);           // out-of-range load
    add(0, 0, 15, 0, OOR_FROM3);
    add(0, 0, 9, 0, 9);                    // max legal load
    add(1, 1, 0, 0, 8);
    add(0, 1, 2, 0, 2, 3);                 // loadn held low reloads
    add(0, 0, 0, 0, 0);                    // load zero
    add(1, 0, 0, 0, 0, 2);                 // zero without enable: no tc

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) apply(vecs[i], i);
    end

    // Asynchronous reset mid-count from 6.
    apply('{1'b0, 1'b0, 4'd6, 1'b0, 4'd6, 1}, 100);
    @(negedge clk);
    loadn = 1'b1; enable = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_zero", int'(zero), 1);
    check("async_rst_tc", int'(tc), 0);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_tc", int'(tc), 1);
    @(posedge clk); #1;
    check("post_rst_wrap", int'(count), 9);
    check("post_rst_tc_after", int'(tc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
